rx_block_lock: RTL and testbench

- Parametrised 64b/66b receive block-lock engine, successor to the simple slip/lock counter.
- Sits between the GT RX gearbox outputs (rxheader/rxheadervalid) and the PCS descrambler/decoder.
- Drives a single-cycle gearbox slip and reports block lock.
- Adds windowed hysteresis, a post-slip settle time, lock-loss reporting and saturating statistics counters.

---
 rtl/rx_block_lock_if.sv | 25 ++
 rtl/rx_block_lock.sv | 117 +++++++++++
 tb/tb_rx_block_lock.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rx_block_lock_if.sv
// Gearbox-side bus for the 64b/66b block-lock engine: header stream in,
// slip request, lock status and statistics out.
interface rx_block_lock_if #(
  parameter int P_STAT_WIDTH = 16
);
  logic                    enable_i;
  logic [1:0]              rxheader_i;
  logic                    rxheadervalid_i;
  logic                    stat_clear_i;
  logic                    rxgearboxslip_o;
  logic                    locked_o;
  logic                    lock_lost_o;
  logic [P_STAT_WIDTH-1:0] slip_count_o;
  logic [P_STAT_WIDTH-1:0] hdr_err_count_o;

  modport slave (
    input  enable_i, rxheader_i, rxheadervalid_i, stat_clear_i,
    output rxgearboxslip_o, locked_o, lock_lost_o, slip_count_o, hdr_err_count_o
  );

  modport master (
    output enable_i, rxheader_i, rxheadervalid_i, stat_clear_i,
    input  rxgearboxslip_o, locked_o, lock_lost_o, slip_count_o, hdr_err_count_o
  );
endinterface

// File: rtl/rx_block_lock.sv
// 64b/66b receive block-lock engine: windowed sync-header test with lock
// hysteresis, registered gearbox slip, post-slip settle and saturating stats.
module rx_block_lock #(
  parameter int P_WINDOW     = 64,
  parameter int P_BAD_LIMIT  = 16,
  parameter int P_SLIP_WAIT  = 32,
  parameter int P_STAT_WIDTH = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  rx_block_lock_if.slave  bus
);
  localparam int CW = $clog2(P_WINDOW + 1);

  typedef enum logic [1:0] {ST_INIT, ST_TEST, ST_SLIP, ST_WAIT} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_sh_cnt, r_bad_cnt;
  logic [7:0]              r_wait_cnt;
  logic                    r_locked, r_slip, r_lock_lost;
  logic [P_STAT_WIDTH-1:0] r_slip_cnt, r_err_cnt;

  logic          w_hdr_bad, w_hdr_qual, w_win_done, w_wait_done;
  logic [CW-1:0] w_sh_inc, w_bad_inc;
  logic          w_cnt_clr, w_cnt_upd, w_set_lock, w_drop_lock, w_err_evt;

  assign w_hdr_bad   = (bus.rxheader_i == 2'b00) || (bus.rxheader_i == 2'b11);
  assign w_hdr_qual  = (r_state == ST_TEST) && bus.rxheadervalid_i && bus.enable_i;
  assign w_sh_inc    = r_sh_cnt + CW'(1);
  assign w_bad_inc   = r_bad_cnt + CW'(w_hdr_bad);
  assign w_win_done  = (w_sh_inc == CW'(P_WINDOW));
  assign w_wait_done = (r_wait_cnt == 8'(P_SLIP_WAIT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_upd   = 1'b0;
    w_set_lock  = 1'b0;
    w_drop_lock = 1'b0;
    w_err_evt   = 1'b0;
    if (!bus.enable_i) begin
      w_state_nxt = ST_INIT;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          w_state_nxt = ST_TEST;
          w_cnt_clr   = 1'b1;
        end
        ST_TEST: if (w_hdr_qual) begin
          w_cnt_upd = 1'b1;
          if (r_locked) begin
            w_err_evt = w_hdr_bad;
            // Lock loss outranks a window that completes on the same header.
            if (w_hdr_bad && (w_bad_inc == CW'(P_BAD_LIMIT))) begin
              w_drop_lock = 1'b1;
              w_state_nxt = ST_SLIP;
            end else if (w_win_done) begin
              w_cnt_clr = 1'b1;
            end
          end else if (w_hdr_bad) begin
            w_state_nxt = ST_SLIP;
          end else if (w_win_done) begin
            w_set_lock = 1'b1;
            w_cnt_clr  = 1'b1;
          end
        end
        ST_SLIP: w_state_nxt = ST_WAIT;
        ST_WAIT: if (w_wait_done) begin
          w_state_nxt = ST_TEST;
          w_cnt_clr   = 1'b1;
        end
        default: w_state_nxt = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_INIT;
      r_sh_cnt    <= '0;
      r_bad_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_locked    <= 1'b0;
      r_slip      <= 1'b0;
      r_lock_lost <= 1'b0;
      r_slip_cnt  <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_clr) begin
        r_sh_cnt  <= '0;
        r_bad_cnt <= '0;
      end else if (w_cnt_upd) begin
        r_sh_cnt  <= w_sh_inc;
        r_bad_cnt <= w_bad_inc;
      end
      r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 8'd1 : 8'd0;
      // Slip pulse is the registered image of entering SLIP.
      r_slip <= (w_state_nxt == ST_SLIP);
      if (!bus.enable_i || w_drop_lock) r_locked <= 1'b0;
      else if (w_set_lock)              r_locked <= 1'b1;
      if (bus.stat_clear_i)  r_lock_lost <= 1'b0;
      else if (w_drop_lock)  r_lock_lost <= 1'b1;
      if (bus.stat_clear_i)              r_slip_cnt <= '0;
      else if (r_slip && !(&r_slip_cnt)) r_slip_cnt <= r_slip_cnt + 1'b1;
      if (bus.stat_clear_i)                r_err_cnt <= '0;
      else if (w_err_evt && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.rxgearboxslip_o = r_slip;
  assign bus.locked_o        = r_locked;
  assign bus.lock_lost_o     = r_lock_lost;
  assign bus.slip_count_o    = r_slip_cnt;
  assign bus.hdr_err_count_o = r_err_cnt;
endmodule

// File: tb/tb_rx_block_lock.sv
// Directed bench for rx_block_lock: stimulus queues expected slip/lock events,
// a negedge monitor pops and compares them; counters are checked directly.
module tb_rx_block_lock;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_block_lock_if #(.P_STAT_WIDTH(SW)) bus();

  rx_block_lock #(
    .P_WINDOW(64), .P_BAD_LIMIT(16), .P_SLIP_WAIT(32), .P_STAT_WIDTH(SW)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int   cyc;
    logic slip;
    logic locked;
    logic lost;
  } evt_t;

  evt_t expq[$];
  evt_t me;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic prev_locked = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any slip pulse or lock-status change is an output event.
  always @(negedge clk) begin
    if (bus.rxgearboxslip_o === 1'b1 || bus.locked_o !== prev_locked) begin
      checks = checks + 1;
      if (expq.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_event cyc=%0d slip=%b locked=%b lost=%b",
                 cyc, bus.rxgearboxslip_o, bus.locked_o, bus.lock_lost_o);
      end else begin
        me = expq.pop_front();
        if (me.cyc != cyc || me.slip !== bus.rxgearboxslip_o ||
            me.locked !== bus.locked_o || me.lost !== bus.lock_lost_o) begin
          errors = errors + 1;
          $display("FAIL event got cyc=%0d slip=%b locked=%b lost=%b expected cyc=%0d slip=%b locked=%b lost=%b",
                   cyc, bus.rxgearboxslip_o, bus.locked_o, bus.lock_lost_o,
                   me.cyc, me.slip, me.locked, me.lost);
        end
      end
    end
    prev_locked <= bus.locked_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] h, input bit ev,
                      input logic e_slip, input logic e_locked, input logic e_lost);
    bus.rxheader_i      = h;
    bus.rxheadervalid_i = 1'b1;
    if (ev) expq.push_back('{cyc + 1, e_slip, e_locked, e_lost});
    tick();
    bus.rxheadervalid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rxheadervalid_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic lock64(input logic e_lost);
    for (int i = 0; i < 64; i++)
      send((i % 2) ? 2'b10 : 2'b01, i == 63, 1'b0, 1'b1, e_lost);
  endtask

  task automatic clear_stats();
    bus.stat_clear_i = 1'b1;
    tick();
    bus.stat_clear_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.enable_i        = 1'b0;
    bus.rxheader_i      = 2'b00;
    bus.rxheadervalid_i = 1'b0;
    bus.stat_clear_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 32'(bus.locked_o), 0);
    chk("rst_slip", 32'(bus.rxgearboxslip_o), 0);
    chk("rst_lost", 32'(bus.lock_lost_o), 0);
    chk("rst_slip_cnt", 32'(bus.slip_count_o), 0);
    chk("rst_err_cnt", 32'(bus.hdr_err_count_o), 0);
    rst_n = 1'b1;
    tick();

    // Acquisition: INIT -> TEST takes one cycle, then 64 clean headers.
    bus.enable_i = 1'b1;
    tick();
    lock64(1'b0);
    chk("acq_locked", 32'(bus.locked_o), 1);
    chk("acq_slip_cnt", 32'(bus.slip_count_o), 0);

    // Hysteresis hold: 15 bad headers in a 64-header window.
    for (int i = 0; i < 64; i++)
      send((i % 4 == 0 && i < 60) ? ((i % 8 == 0) ? 2'b11 : 2'b00) : 2'b01,
           1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_locked", 32'(bus.locked_o), 1);
    chk("hold_err_cnt", 32'(bus.hdr_err_count_o), 15);
    chk("hold_slip_cnt", 32'(bus.slip_count_o), 0);
    clear_stats();
    chk("clr_err_cnt", 32'(bus.hdr_err_count_o), 0);

    // Lock loss on 16th bad header; headers during SLIP+WAIT are ignored.
    for (int i = 0; i < 16; i++) send(2'b00, i == 15, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 33; i++) send(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("loss_locked", 32'(bus.locked_o), 0);
    chk("loss_lost", 32'(bus.lock_lost_o), 1);
    chk("loss_slip_cnt", 32'(bus.slip_count_o), 1);
    chk("loss_err_sat", 32'(bus.hdr_err_count_o), 15);
    lock64(1'b1);
    chk("relock_locked", 32'(bus.locked_o), 1);
    chk("relock_slip_cnt", 32'(bus.slip_count_o), 1);

    // Boundary: 16th bad header is also the 64th header of the window.
    clear_stats();
    chk("clr_lost", 32'(bus.lock_lost_o), 0);
    for (int i = 0; i < 64; i++)
      send((i < 48) ? 2'b10 : 2'b11, i == 63, 1'b1, 1'b0, 1'b1);
    idle(33);
    chk("edge_locked", 32'(bus.locked_o), 0);
    chk("edge_lost", 32'(bus.lock_lost_o), 1);
    chk("edge_slip_cnt", 32'(bus.slip_count_o), 1);

    // Saturation: 20 slips on a 4-bit counter.
    clear_stats();
    for (int k = 0; k < 20; k++) begin
      send(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(33);
    end
    chk("sat_slip_cnt", 32'(bus.slip_count_o), 15);
    clear_stats();
    chk("sat_clr_slip_cnt", 32'(bus.slip_count_o), 0);
    chk("sat_clr_lost", 32'(bus.lock_lost_o), 0);
    // Clear coinciding with the slip cycle wins over the increment.
    send(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.stat_clear_i = 1'b1;
    tick();
    bus.stat_clear_i = 1'b0;
    idle(32);
    chk("clr_prio_slip_cnt", 32'(bus.slip_count_o), 0);

    // Disable while locked: lock drops next cycle, not reported as loss.
    lock64(1'b0);
    bus.enable_i = 1'b0;
    expq.push_back('{cyc + 1, 1'b0, 1'b0, 1'b0});
    tick();
    chk("dis_locked", 32'(bus.locked_o), 0);
    chk("dis_lost", 32'(bus.lock_lost_o), 0);

    // Reset during WAIT, then a full 64-header relock is needed.
    bus.enable_i = 1'b1;
    tick();
    send(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);
    chk("wait_slip_cnt", 32'(bus.slip_count_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_slip_cnt", 32'(bus.slip_count_o), 0);
    chk("arst_slip", 32'(bus.rxgearboxslip_o), 0);
    chk("arst_locked", 32'(bus.locked_o), 0);
    chk("arst_lost", 32'(bus.lock_lost_o), 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 63; i++) send((i % 2) ? 2'b10 : 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_63_locked", 32'(bus.locked_o), 0);
    send(2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("post_rst_locked", 32'(bus.locked_o), 1);

    idle(3);
    chk("evt_queue_drained", 32'(expq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
